// File: rtl/ram_axil_slave.sv
// ram_axil_slave: AXI4-Lite slave responder backed by a word-addressed RAM.
// Optional macro RAM_AXIL_SLAVE_RD_PIPE_EN adds an output register stage
// after the RAM read (read latency 2 instead of 1).
module ram_axil_slave #(
  parameter int unsigned C_S_AXI_DATA_WIDTH = 32,
  parameter int unsigned C_S_AXI_ADDR_WIDTH = 8,
  parameter int unsigned MEM_DEPTH          = 16
) (
  input  logic                              ACLK,
  input  logic                              ARESET,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_AWADDR,
  input  logic [2:0]                        S_AXI_AWPROT,
  input  logic                              S_AXI_AWVALID,
  output logic                              S_AXI_AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0]   S_AXI_WSTRB,
  input  logic                              S_AXI_WVALID,
  output logic                              S_AXI_WREADY,
  output logic [1:0]                        S_AXI_BRESP,
  output logic                              S_AXI_BVALID,
  input  logic                              S_AXI_BREADY,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]     S_AXI_ARADDR,
  input  logic [2:0]                        S_AXI_ARPROT,
  input  logic                              S_AXI_ARVALID,
  output logic                              S_AXI_ARREADY,
  output logic [C_S_AXI_DATA_WIDTH-1:0]     S_AXI_RDATA,
  output logic [1:0]                        S_AXI_RRESP,
  output logic                              S_AXI_RVALID,
  input  logic                              S_AXI_RREADY
);
  localparam int unsigned DW = C_S_AXI_DATA_WIDTH;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned IW = C_S_AXI_ADDR_WIDTH - 2;
  localparam int unsigned MW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  logic [DW-1:0] mem [MEM_DEPTH];

  function automatic logic in_range(input logic [IW-1:0] idx);
    return 32'(idx) < MEM_DEPTH;
  endfunction

  // write channel state
  logic          aw_full_q, aw_full_d, w_full_q, w_full_d;
  logic [IW-1:0] aw_idx_q, aw_idx_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic [SW-1:0] wstrb_q, wstrb_d;
  logic          bvalid_q, bvalid_d, awready_q, awready_d, wready_q, wready_d;
  logic [1:0]    bresp_q, bresp_d;
  logic          aw_hs, w_hs, b_hs, commit, cm_ok;
  logic [IW-1:0] cm_idx;
  logic [DW-1:0] cm_data;
  logic [SW-1:0] cm_strb;

  // read channel state
  logic          arready_q, arready_d, rvalid_q, rvalid_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic [1:0]    rresp_q, rresp_d;
  logic          ar_hs, r_hs, rd_fire, rd_ok, inflight_d;
  logic [IW-1:0] ar_idx, rd_idx;
`ifdef RAM_AXIL_SLAVE_RD_PIPE_EN
  logic          p1_valid_q, p1_valid_d, p1_ok_q, p1_ok_d;
  logic [IW-1:0] p1_idx_q, p1_idx_d;
`endif

  logic unused_inputs;
  assign unused_inputs = ^{S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0]};

  // write next-state: buffer AW/W independently, commit once both are present
  always_comb begin
    aw_hs   = S_AXI_AWVALID && awready_q;
    w_hs    = S_AXI_WVALID && wready_q;
    b_hs    = bvalid_q && S_AXI_BREADY;
    cm_idx  = aw_full_q ? aw_idx_q : S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    cm_data = w_full_q ? wdata_q : S_AXI_WDATA;
    cm_strb = w_full_q ? wstrb_q : S_AXI_WSTRB;
    cm_ok   = in_range(cm_idx);
    commit  = (aw_full_q || aw_hs) && (w_full_q || w_hs) && !bvalid_q;
    aw_full_d = aw_full_q;
    aw_idx_d  = aw_idx_q;
    w_full_d  = w_full_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    bvalid_d  = bvalid_q;
    bresp_d   = bresp_q;
    if (aw_hs) begin
      aw_full_d = 1'b1;
      aw_idx_d  = S_AXI_AWADDR[C_S_AXI_ADDR_WIDTH-1:2];
    end
    if (w_hs) begin
      w_full_d = 1'b1;
      wdata_d  = S_AXI_WDATA;
      wstrb_d  = S_AXI_WSTRB;
    end
    if (commit) begin
      bvalid_d = 1'b1;
      bresp_d  = cm_ok ? RESP_OKAY : RESP_SLVERR;
    end
    if (b_hs) begin
      bvalid_d  = 1'b0;
      aw_full_d = 1'b0;
      w_full_d  = 1'b0;
    end
    awready_d = !aw_full_d && !bvalid_d;
    wready_d  = !w_full_d && !bvalid_d;
  end

  // write channel registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      aw_full_q <= 1'b0;
      aw_idx_q  <= '0;
      w_full_q  <= 1'b0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
    end else begin
      aw_full_q <= aw_full_d;
      aw_idx_q  <= aw_idx_d;
      w_full_q  <= w_full_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
    end
  end

  // RAM byte-lane write on commit; contents are never reset
  always_ff @(posedge ACLK) begin
    if (!ARESET && commit && cm_ok) begin
      for (int b = 0; b < int'(SW); b++) begin
        if (cm_strb[b]) mem[MW'(cm_idx)][b*8 +: 8] <= cm_data[b*8 +: 8];
      end
    end
  end

  // read next-state: RAM is sampled combinationally so a same-edge write is not seen
  always_comb begin
    ar_hs  = S_AXI_ARVALID && arready_q;
    r_hs   = rvalid_q && S_AXI_RREADY;
    ar_idx = S_AXI_ARADDR[C_S_AXI_ADDR_WIDTH-1:2];
`ifdef RAM_AXIL_SLAVE_RD_PIPE_EN
    p1_valid_d = ar_hs;
    p1_idx_d   = ar_hs ? ar_idx : p1_idx_q;
    p1_ok_d    = ar_hs ? in_range(ar_idx) : p1_ok_q;
    rd_fire    = p1_valid_q;
    rd_idx     = p1_idx_q;
    rd_ok      = p1_ok_q;
    inflight_d = p1_valid_d;
`else
    rd_fire    = ar_hs;
    rd_idx     = ar_idx;
    rd_ok      = in_range(ar_idx);
    inflight_d = 1'b0;
`endif
    rvalid_d = rvalid_q;
    rdata_d  = rdata_q;
    rresp_d  = rresp_q;
    if (r_hs) rvalid_d = 1'b0;
    if (rd_fire) begin
      rvalid_d = 1'b1;
      rdata_d  = rd_ok ? mem[MW'(rd_idx)] : '0;
      rresp_d  = rd_ok ? RESP_OKAY : RESP_SLVERR;
    end
    arready_d = !rvalid_d && !inflight_d;
  end

  // read channel registers
  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
`ifdef RAM_AXIL_SLAVE_RD_PIPE_EN
      p1_valid_q <= 1'b0;
      p1_idx_q   <= '0;
      p1_ok_q    <= 1'b0;
`endif
    end else begin
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
`ifdef RAM_AXIL_SLAVE_RD_PIPE_EN
      p1_valid_q <= p1_valid_d;
      p1_idx_q   <= p1_idx_d;
      p1_ok_q    <= p1_ok_d;
`endif
    end
  end

  assign S_AXI_AWREADY = awready_q;
  assign S_AXI_WREADY  = wready_q;
  assign S_AXI_BVALID  = bvalid_q;
  assign S_AXI_BRESP   = bresp_q;
  assign S_AXI_ARREADY = arready_q;
  assign S_AXI_RVALID  = rvalid_q;
  assign S_AXI_RDATA   = rdata_q;
  assign S_AXI_RRESP   = rresp_q;

endmodule

// File: tb/tb_ram_axil_slave.sv
// Testbench for ram_axil_slave: directed steps plus randomized traffic
// checked against a word-array model of the memory.
module tb_ram_axil_slave;
  localparam int DEPTH = 16;
`ifdef RAM_AXIL_SLAVE_RD_PIPE_EN
  localparam int RD_LAT = 2;
`else
  localparam int RD_LAT = 1;
`endif

  logic        ACLK = 1'b0;
  logic        ARESET;
  logic [7:0]  S_AXI_AWADDR, S_AXI_ARADDR;
  logic [2:0]  S_AXI_AWPROT, S_AXI_ARPROT;
  logic        S_AXI_AWVALID, S_AXI_AWREADY, S_AXI_WVALID, S_AXI_WREADY;
  logic [31:0] S_AXI_WDATA, S_AXI_RDATA;
  logic [3:0]  S_AXI_WSTRB;
  logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
  logic        S_AXI_BVALID, S_AXI_BREADY, S_AXI_ARVALID, S_AXI_ARREADY;
  logic        S_AXI_RVALID, S_AXI_RREADY;

  int checks = 0;
  int errors = 0;
  logic [31:0] mdl [DEPTH];

  ram_axil_slave dut (
    .ACLK(ACLK), .ARESET(ARESET),
    .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT),
    .S_AXI_AWVALID(S_AXI_AWVALID), .S_AXI_AWREADY(S_AXI_AWREADY),
    .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
    .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY),
    .S_AXI_BRESP(S_AXI_BRESP), .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
    .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT),
    .S_AXI_ARVALID(S_AXI_ARVALID), .S_AXI_ARREADY(S_AXI_ARREADY),
    .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
    .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY)
  );

  always #5 ACLK = ~ACLK;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] s);
    logic [31:0] r = old;
    for (int b = 0; b < 4; b++) if (s[b]) r[b*8 +: 8] = d[b*8 +: 8];
    return r;
  endfunction

  task automatic do_write(input logic [7:0] addr, input logic [31:0] data, input logic [3:0] strb,
                          input int aw_dly, input int w_dly, input int b_dly);
    bit aw_done = 0;
    bit w_done = 0;
    int cyc = 0;
    int idx = int'(addr >> 2);
    logic [1:0] exp_resp = (idx < DEPTH) ? 2'b00 : 2'b10;
    while (!(aw_done && w_done) && cyc < 40) begin
      S_AXI_AWADDR  = addr;
      S_AXI_WDATA   = data;
      S_AXI_WSTRB   = strb;
      S_AXI_AWVALID = !aw_done && cyc >= aw_dly;
      S_AXI_WVALID  = !w_done && cyc >= w_dly;
      chk("awready", 32'(S_AXI_AWREADY), 32'(!aw_done));
      chk("wready", 32'(S_AXI_WREADY), 32'(!w_done));
      chk("bvalid_early", 32'(S_AXI_BVALID), 32'd0);
      if (S_AXI_AWVALID && S_AXI_AWREADY) aw_done = 1;
      if (S_AXI_WVALID && S_AXI_WREADY) w_done = 1;
      tick();
      cyc++;
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    chk("aw_w_handshake", 32'(aw_done && w_done), 32'd1);
    chk("bvalid_latency", 32'(S_AXI_BVALID), 32'd1);
    chk("bresp", 32'(S_AXI_BRESP), 32'(exp_resp));
    if (idx < DEPTH) mdl[idx] = merge(mdl[idx], data, strb);
    for (int i = 0; i < b_dly; i++) begin
      tick();
      chk("bvalid_hold", 32'(S_AXI_BVALID), 32'd1);
      chk("bresp_hold", 32'(S_AXI_BRESP), 32'(exp_resp));
      chk("awready_stall", 32'(S_AXI_AWREADY), 32'd0);
      chk("wready_stall", 32'(S_AXI_WREADY), 32'd0);
    end
    S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_BREADY = 1'b0;
    chk("bvalid_clear", 32'(S_AXI_BVALID), 32'd0);
    chk("awready_free", 32'(S_AXI_AWREADY), 32'd1);
  endtask

  task automatic do_read(input logic [7:0] addr, input int ar_dly, input int r_dly);
    bit done = 0;
    int cyc = 0;
    int idx = int'(addr >> 2);
    logic [31:0] exp_data = (idx < DEPTH) ? mdl[idx] : 32'h0;
    logic [1:0]  exp_resp = (idx < DEPTH) ? 2'b00 : 2'b10;
    while (!done && cyc < 40) begin
      S_AXI_ARADDR  = addr;
      S_AXI_ARVALID = cyc >= ar_dly;
      if (S_AXI_ARVALID && S_AXI_ARREADY) done = 1;
      tick();
      cyc++;
    end
    S_AXI_ARVALID = 1'b0;
    chk("ar_handshake", 32'(done), 32'd1);
    for (int i = 1; i < RD_LAT; i++) begin
      chk("rvalid_pipe", 32'(S_AXI_RVALID), 32'd0);
      chk("arready_pipe", 32'(S_AXI_ARREADY), 32'd0);
      tick();
    end
    chk("rvalid_latency", 32'(S_AXI_RVALID), 32'd1);
    chk("rdata", S_AXI_RDATA, exp_data);
    chk("rresp", 32'(S_AXI_RRESP), 32'(exp_resp));
    chk("arready_busy", 32'(S_AXI_ARREADY), 32'd0);
    for (int i = 0; i < r_dly; i++) begin
      tick();
      chk("rvalid_hold", 32'(S_AXI_RVALID), 32'd1);
      chk("rdata_hold", S_AXI_RDATA, exp_data);
      chk("rresp_hold", 32'(S_AXI_RRESP), 32'(exp_resp));
    end
    S_AXI_RREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0;
    chk("rvalid_clear", 32'(S_AXI_RVALID), 32'd0);
    chk("arready_free", 32'(S_AXI_ARREADY), 32'd1);
  endtask

  initial begin
    logic [31:0] old_w3;
    ARESET = 1'b1;
    S_AXI_AWADDR = '0; S_AXI_AWPROT = '0; S_AXI_AWVALID = 1'b0;
    S_AXI_WDATA = '0; S_AXI_WSTRB = '0; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
    S_AXI_ARADDR = '0; S_AXI_ARPROT = '0; S_AXI_ARVALID = 1'b0; S_AXI_RREADY = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl[i] = 32'h0;
    repeat (3) tick();

    // reset values
    chk("rst_awready", 32'(S_AXI_AWREADY), 32'd0);
    chk("rst_wready", 32'(S_AXI_WREADY), 32'd0);
    chk("rst_arready", 32'(S_AXI_ARREADY), 32'd0);
    chk("rst_bvalid", 32'(S_AXI_BVALID), 32'd0);
    chk("rst_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_bresp", 32'(S_AXI_BRESP), 32'd0);
    chk("rst_rresp", 32'(S_AXI_RRESP), 32'd0);
    chk("rst_rdata", S_AXI_RDATA, 32'd0);
    ARESET = 1'b0;
    tick();
    chk("idle_arready", 32'(S_AXI_ARREADY), 32'd1);

    // four words then read back
    for (int i = 0; i < 4; i++) do_write(8'(i * 4), 32'(i + 1), 4'hF, 0, 0, 0);
    for (int i = 0; i < 4; i++) do_read(8'(i * 4), 0, 0);

    // byte strobes merge into the existing word
    do_write(8'h10, 32'hAABBCCDD, 4'hF, 0, 0, 0);
    do_write(8'h10, 32'h11223344, 4'h5, 0, 0, 0);
    do_read(8'h10, 0, 0);

    // W delayed five cycles after AW
    do_write(8'h18, 32'hCAFEBABE, 4'hF, 0, 5, 0);
    do_read(8'h18, 0, 0);

    // out-of-range index 16, then word 0 unchanged
    do_write(8'h40, 32'hDEADBEEF, 4'hF, 0, 0, 0);
    do_read(8'h40, 0, 0);
    do_read(8'h00, 0, 0);

    // B held off ten cycles, then R held off a few
    do_write(8'h1C, 32'h0BADF00D, 4'hF, 1, 0, 10);
    do_read(8'h1C, 2, 4);

    // zero strobe writes nothing, still OKAY
    do_write(8'h08, 32'hFFFFFFFF, 4'h0, 0, 0, 0);
    do_read(8'h08, 0, 0);

    // read RAM access in the same cycle as a write commit to the same word
    old_w3 = mdl[3];
    S_AXI_ARADDR = 8'h0C; S_AXI_ARVALID = 1'b1;
    S_AXI_AWADDR = 8'h0C; S_AXI_WDATA = 32'h5A5AF00D; S_AXI_WSTRB = 4'hF;
    S_AXI_AWVALID = (RD_LAT == 1);
    S_AXI_WVALID  = (RD_LAT == 1);
    tick();
    S_AXI_ARVALID = 1'b0;
    if (RD_LAT == 2) begin
      S_AXI_AWVALID = 1'b1;
      S_AXI_WVALID  = 1'b1;
      tick();
    end
    S_AXI_AWVALID = 1'b0;
    S_AXI_WVALID  = 1'b0;
    chk("coll_rvalid", 32'(S_AXI_RVALID), 32'd1);
    chk("coll_bvalid", 32'(S_AXI_BVALID), 32'd1);
    chk("coll_rdata_old", S_AXI_RDATA, old_w3);
    S_AXI_RREADY = 1'b1; S_AXI_BREADY = 1'b1;
    tick();
    S_AXI_RREADY = 1'b0; S_AXI_BREADY = 1'b0;
    mdl[3] = 32'h5A5AF00D;
    do_read(8'h0C, 0, 0);

    // reset while R is pending and the AW buffer holds a write to word 0
    S_AXI_ARADDR = 8'h04; S_AXI_ARVALID = 1'b1;
    tick();
    S_AXI_ARVALID = 1'b0;
    repeat (RD_LAT - 1) tick();
    chk("mid_rvalid", 32'(S_AXI_RVALID), 32'd1);
    S_AXI_AWADDR = 8'h00; S_AXI_AWVALID = 1'b1;
    tick();
    S_AXI_AWVALID = 1'b0;
    chk("mid_awready", 32'(S_AXI_AWREADY), 32'd0);
    ARESET = 1'b1;
    tick();
    ARESET = 1'b0;
    chk("rst_drop_rvalid", 32'(S_AXI_RVALID), 32'd0);
    chk("rst_drop_bvalid", 32'(S_AXI_BVALID), 32'd0);
    tick();
    chk("post_rst_awready", 32'(S_AXI_AWREADY), 32'd1);
    chk("post_rst_wready", 32'(S_AXI_WREADY), 32'd1);
    do_write(8'h24, 32'h13572468, 4'hF, 2, 0, 0);
    do_read(8'h00, 0, 0);
    do_read(8'h24, 0, 0);

    // randomized traffic against the model
    for (int i = 0; i < DEPTH; i++) do_write(8'(i * 4), $urandom, 4'hF, 0, 0, 0);
    for (int n = 0; n < 60; n++) begin
      logic [7:0] a;
      a = 8'(($urandom_range(0, 19) << 2) | $urandom_range(0, 3));
      if ($urandom_range(0, 1) == 1)
        do_write(a, $urandom, 4'($urandom), $urandom_range(0, 3), $urandom_range(0, 3),
                 $urandom_range(0, 2));
      else
        do_read(a, $urandom_range(0, 2), $urandom_range(0, 2));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ram_axil_slave.md
Name: ram_axil_slave

Overview:
AXI4-Lite slave responder backed by an internal word-addressed RAM. It is the memory end of the RAM IP: it accepts the single-beat writes and reads issued by the master agent or processor, and it answers with OKAY or SLVERR responses. It sits behind the IP's S00_AXI port and replaces the fixed 4-register slave with a parameterised-depth store.

Parameters:
C_S_AXI_DATA_WIDTH, 32, data bus width; only 32 is supported.
C_S_AXI_ADDR_WIDTH, 8, byte address width.
MEM_DEPTH, 16, number of 32-bit words; must be <= 2^(C_S_AXI_ADDR_WIDTH-2).

Ports:
ACLK  in  1  clock, all logic rising-edge.
ARESET  in  1  reset, synchronous, active-high.
S_AXI_AWADDR  in  C_S_AXI_ADDR_WIDTH  write address.
S_AXI_AWPROT  in  3  ignored.
S_AXI_AWVALID / S_AXI_AWREADY  in / out  1  write address handshake.
S_AXI_WDATA  in  32  write data.
S_AXI_WSTRB  in  4  byte enables.
S_AXI_WVALID / S_AXI_WREADY  in / out  1  write data handshake.
S_AXI_BRESP  out  2  write response.
S_AXI_BVALID / S_AXI_BREADY  out / in  1  write response handshake.
S_AXI_ARADDR  in  C_S_AXI_ADDR_WIDTH  read address.
S_AXI_ARPROT  in  3  ignored.
S_AXI_ARVALID / S_AXI_ARREADY  in / out  1  read address handshake.
S_AXI_RDATA  out  32  read data.
S_AXI_RRESP  out  2  read response.
S_AXI_RVALID / S_AXI_RREADY  out / in  1  read data handshake.

Behaviour:
- Reset state: all READY, VALID, RESP and RDATA outputs are 0. The AW and W holding buffers are cleared. RAM contents are not reset.
- ARESET asserted mid-transaction: all pending transactions are dropped. VALIDs read 0 from the cycle after the reset edge. No partial RAM write occurs unless the commit cycle has already passed.
- Word index: addr[C_S_AXI_ADDR_WIDTH-1:2]. Address bits [1:0] are ignored.
- Index >= MEM_DEPTH is out of range: the write is discarded and BRESP=2'b10; the read returns RDATA=0 and RRESP=2'b10. Otherwise the response is 2'b00.
- Write channel: AW and W each have a one-entry buffer and are accepted independently, in either order or in the same cycle.
  - AWREADY=1 when the AW buffer is empty and BVALID=0. WREADY follows the same rule with the W buffer.
  - Once both buffers are full, the RAM is updated in the next cycle (commit) using per-byte WSTRB. WSTRB=0 writes nothing but still returns OKAY.
  - BVALID rises in the commit cycle and holds with a stable BRESP until BREADY. Both buffers are freed on B handshake.
  - Minimum AW+W-to-BVALID latency: 1 cycle.
- Read channel:
  - ARREADY=1 when no read is in flight and RVALID=0.
  - An AR handshake at cycle N gives RVALID=1 at N+1.
  - RDATA and RRESP stay stable while RVALID=1 and RREADY=0. ARREADY stays 0 until the R handshake completes.
- Write/read collision: a read whose RAM access falls in the same cycle as a write commit to the same word returns the pre-write data (read-before-write). Later reads see the new data.
- Channel independence: read and write channels never block each other.
- Throughput: at most one outstanding transaction per channel.
  - Back-to-back writes: one every 2 cycles with BREADY tied high.
  - Back-to-back reads: one every 2 cycles with RREADY tied high.

Optional Feature:
RAM_AXIL_SLAVE_RD_PIPE_EN
- Defined: an output register stage is added after the RAM read. AR handshake at N gives RVALID at N+2, and ARREADY stays 0 during both cycles.
  - The collision rule applies to the RAM access cycle (N+1).
  - Out-of-range detection is carried through the pipe.
- Undefined: read latency is 1 cycle, as described in Behaviour.

Test Plan:
- Reset, then 4 writes of 0x1,0x2,0x3,0x4 to 0x00,0x04,0x08,0x0C with WSTRB=0xF, then 4 reads of the same addresses -> each BRESP=0; RDATA=1,2,3,4; RRESP=0.
- Write 0xAABBCCDD to 0x10 with WSTRB=0xF, then 0x11223344 with WSTRB=0x5, then read 0x10 -> 0xAA22CC44.
- AWVALID on cycle 0, WVALID delayed to cycle 5 -> AWREADY pulses at cycle 0; BVALID first high at cycle 6; data committed.
- Write and read at 0x40 (index 16, MEM_DEPTH=16) -> BRESP=2'b10, RRESP=2'b10, RDATA=0. A subsequent read of 0x00 is unchanged.
- BREADY held low for 10 cycles after a write -> BVALID stays 1 with BRESP stable; AWREADY=WREADY=0 throughout. Completes once BREADY=1.
- ARESET pulsed 1 cycle while RVALID=1 and the AW buffer is full -> RVALID=0 and BVALID=0 the next cycle. The buffered write is never committed (read-back shows old data).
